// File: rtl/dmem_access_unit_if.sv
// Data-memory request/ack bus between the MEM-stage access unit and a variable-latency memory.
// The master holds a request with stable address/data until the memory acks it or the master aborts.
interface dmem_access_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store controller: stalls the pipeline for 1 + (REQ cycles) per aligned access.
// Backpressure is the memory ack; a missing ack aborts after ACK_TIMEOUT REQ cycles with a sticky error.
module dmem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [4:0]  WriteBackPath_i,
    dmem_access_unit_if.master mem,
    output logic        stall_o,
    output logic [31:0] mux0_o,
    output logic [31:0] mux1_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [4:0]  WriteBackPath_o,
    output logic        err_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        stall;

    logic access, misaligned;
    assign access     = MemRead_i | MemWrite_i;
    assign misaligned = access & (addr_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    // Both MemRead and MemWrite high resolves to a write.
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                    stall   = 1'b1;
                end else if (misaligned) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem.mem_ack_i) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = mem.mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = 32'hDEADBEEF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // DONE lets EX/MEM advance without looking at the still-present old instruction.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;

    // Held-over access inputs must not freeze the pipeline while reset is asserted.
    assign stall_o         = rst_n_i & stall;
    assign mux0_o          = addr_i;
    assign mux1_o          = rdata_q;
    assign RegWrite_o      = RegWrite_i & ~stall_o;
    assign MemtoReg_o      = MemtoReg_i;
    assign WriteBackPath_o = WriteBackPath_i;
    assign err_o           = err_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: transaction-level model of stall count, REQ count, load data and sticky error.
module tb_dmem_access_unit;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] addr, wdata;
    logic [4:0]  wbp;
    logic        stall, RegWrite_o, MemtoReg_o, err;
    logic [31:0] mux0, mux1;
    logic [4:0]  wbp_o;

    dmem_access_unit_if mem_if ();

    dmem_access_unit #(.ACK_TIMEOUT(T)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .MemRead_i       (MemRead),
        .MemWrite_i      (MemWrite),
        .addr_i          (addr),
        .wdata_i         (wdata),
        .RegWrite_i      (RegWrite),
        .MemtoReg_i      (MemtoReg),
        .WriteBackPath_i (wbp),
        .mem             (mem_if.master),
        .stall_o         (stall),
        .mux0_o          (mux0),
        .mux1_o          (mux1),
        .RegWrite_o      (RegWrite_o),
        .MemtoReg_o      (MemtoReg_o),
        .WriteBackPath_o (wbp_o),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issues one instruction from EX/MEM; the memory acks on REQ cycle ack_k (never if ack_k > T).
    task automatic run_instr(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic rw, input int ack_k, input logic [31:0] rdat);
        logic        acc, mis, tmo, prev_req, st, mtr;
        logic [4:0]  dst;
        logic [31:0] word_addr;
        int          exp_req, exp_stall, stalls, reqs, reqcyc, cyc;
        acc       = rd | wr;
        mis       = acc && (a[1:0] != 2'b00);
        word_addr = {a[31:2], 2'b00};
        exp_req   = (acc && !mis) ? ((ack_k <= T) ? ack_k : T) : 0;
        exp_stall = (acc && !mis) ? 1 + exp_req : 0;
        tmo       = acc && !mis && (ack_k > T);
        mtr       = 1'($urandom);
        dst       = 5'($urandom);
        stalls = 0; reqs = 0; reqcyc = 0; prev_req = 1'b0;

        MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
        RegWrite = rw; MemtoReg = mtr; wbp = dst;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (mem_if.mem_req_o) begin
                reqcyc++;
                if (!prev_req) reqs++;
                chk("mem_addr", mem_if.mem_addr_o, word_addr);
                chk("mem_we", 32'(mem_if.mem_we_o), 32'(wr));
                if (wr) chk("mem_wdata", mem_if.mem_wdata_o, wd);
                mem_if.mem_ack_i   = (reqcyc == ack_k);
                mem_if.mem_rdata_i = (reqcyc == ack_k) ? rdat : $urandom;
            end else begin
                mem_if.mem_ack_i   = ($urandom_range(0, 2) == 0);
                mem_if.mem_rdata_i = $urandom;
            end
            prev_req = mem_if.mem_req_o;
            #1;
            st = stall;
            chk("regwrite_squash", 32'(RegWrite_o), 32'(rw & ~st));
            if (!st) break;
            stalls++;
            @(negedge clk);
        end
        chk("stall_bounded", 32'(cyc < 300), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("req_cycles", 32'(reqcyc), 32'(exp_req));
        chk("req_issues", 32'(reqs), (exp_req > 0) ? 32'd1 : 32'd0);
        chk("mux0", mux0, a);
        chk("memtoreg", 32'(MemtoReg_o), 32'(mtr));
        chk("wbpath", 32'(wbp_o), 32'(dst));

        if (mis) begin
            m_rdata = 32'h0;
            m_err   = 1'b1;
        end else if (acc) begin
            if (!wr) m_rdata = tmo ? 32'hDEADBEEF : rdat;
            if (tmo) m_err = 1'b1;
        end

        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        mem_if.mem_ack_i   = 1'($urandom);
        mem_if.mem_rdata_i = $urandom;
        #1;
        chk("mux1", mux1, m_rdata);
        chk("err", 32'(err), 32'(m_err));
        chk("nop_stall", 32'(stall), 32'd0);
        chk("nop_req", 32'(mem_if.mem_req_o), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        int          k;

        rst_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
        addr = '0; wdata = '0; wbp = '0;
        mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = '0;
        #1;
        chk("rst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_if.mem_we_o), 32'd0);
        chk("rst_addr", mem_if.mem_addr_o, 32'd0);
        chk("rst_wdata", mem_if.mem_wdata_o, 32'd0);
        chk("rst_mux1", mux1, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: load with late ack, store with immediate ack, misaligned load, timeout.
        run_instr(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 3, 32'hCAFEF00D);
        run_instr(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 1'b0, 1, 32'h5555_AAAA);
        run_instr(1'b1, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 1, 32'h1111_1111);
        run_instr(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 99, 32'h2222_2222);
        // Load, ALU op, load back to back.
        run_instr(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 2, 32'hA5A5_0001);
        run_instr(1'b0, 1'b0, 32'h0000_0777, 32'h0, 1'b1, 1, 32'hFFFF_FFFF);
        run_instr(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 1, 32'hA5A5_0002);
        run_instr(1'b1, 1'b1, 32'h0000_0048, 32'hBEEF_0003, 1'b0, 2, 32'h3333_3333);

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            k  = $urandom_range(1, T + 2);
            run_instr(rd, wr, a, $urandom, 1'($urandom), k, $urandom);
        end

        // Reset in the middle of a pending load, with the error flag set beforehand.
        run_instr(1'b0, 1'b1, 32'h0000_0501, 32'h0, 1'b0, 1, 32'h0);
        MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h0000_0400; RegWrite = 1'b1;
        mem_if.mem_ack_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_if.mem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreq_rst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("midreq_rst_stall", 32'(stall), 32'd0);
        chk("midreq_rst_err", 32'(err), 32'd0);
        m_rdata = 32'h0; m_err = 1'b0;
        @(negedge clk);
        MemRead = 1'b0; RegWrite = 1'b0;
        mem_if.mem_ack_i = 1'b1; mem_if.mem_rdata_i = 32'h9999_9999;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("late_ack_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("late_ack_mux1", mux1, m_rdata);
        chk("late_ack_err", 32'(err), 32'(m_err));
        mem_if.mem_ack_i = 1'b0;
        @(negedge clk);
        run_instr(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1, 1, 32'h0BAD_CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
